crop_max_buffer: RTL and testbench

CROP_MAX_BUFFER -- requirements
Module: crop_max_buffer

---
 rtl/crop_max_buffer_if.sv | 19 +
 rtl/crop_max_buffer.sv | 217 +++++++++++++++++++++
 tb/tb_crop_max_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/crop_max_buffer_if.sv
// Byte-wide valid/ready stream bundle used for pixel input and output.
// Signals: tvalid, tready, tdata[7:0]; master drives valid/data, slave drives ready.
interface crop_max_buffer_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/crop_max_buffer.sv
// Captures a raster frame, buffers a crop window, tracks its max, replays it.
// Ports: clk, reset (sync, high), ap_start/ap_ready/ap_done, crop origins,
// s_axis (frame in), m_axis (crop out), norm_denominator(+_tvalid).
// Option: CROP_MAX_ZERO_CLAMP_EN presents a zero max as 1.
module crop_max_buffer #(
  parameter int IN_ROWS  = 16,
  parameter int IN_COLS  = 16,
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10,
  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1,
  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  output logic                 ap_ready,
  output logic                 ap_done,
  input  logic [RW-1:0]        crop_row_start,
  input  logic [CW-1:0]        crop_col_start,
  crop_max_buffer_if.slave     s_axis,
  crop_max_buffer_if.master    m_axis,
  output logic [7:0]           norm_denominator,
  output logic                 norm_denominator_tvalid
);

  localparam int N  = OUT_ROWS * OUT_COLS;
  localparam int AW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [RW-1:0] ROW_LIM = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] COL_LIM = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] ROW_END = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] COL_END = CW'(IN_COLS - 1);
  localparam logic [RW:0]   ROW_SPAN = (RW+1)'(OUT_ROWS);
  localparam logic [CW:0]   COL_SPAN = (CW+1)'(OUT_COLS);
  localparam logic [AW-1:0] N_A    = AW'(N);
  localparam logic [AW-1:0] LAST_A = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EMIT
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d, row0_q, row0_d;
  logic [CW-1:0] col_q, col_d, col0_q, col0_d;
  logic [7:0]    max_q, max_d;
  logic [7:0]    m_data_q, m_data_d;
  logic [7:0]    norm_q, norm_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] sent_q, sent_d;
  logic          ap_ready_q, ap_ready_d;
  logic          ap_done_q, ap_done_d;
  logic          s_rdy_q, s_rdy_d;
  logic          m_vld_q, m_vld_d;
  logic          norm_vld_q, norm_vld_d;

  logic [7:0]    mem [N];

  logic          beat, in_win, wr_en, last_beat;
  logic          issue, xfer;
  logic [RW:0]   row_rel;
  logic [CW:0]   col_rel;
  logic [7:0]    max_nxt;

  function automatic logic [7:0] norm_of(input logic [7:0] m);
`ifdef CROP_MAX_ZERO_CLAMP_EN
    norm_of = (m == 8'd0) ? 8'd1 : m;
`else
    norm_of = m;
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    row0_d     = row0_q;
    col0_d     = col0_q;
    max_d      = max_q;
    m_data_d   = m_data_q;
    norm_d     = norm_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    sent_d     = sent_q;
    ap_ready_d = ap_ready_q;
    ap_done_d  = 1'b0;
    s_rdy_d    = s_rdy_q;
    m_vld_d    = m_vld_q;
    norm_vld_d = norm_vld_q;

    beat      = (state_q == CAPTURE) && s_rdy_q && s_axis.tvalid;
    // Zero-extended offsets so row0+OUT_ROWS == IN_ROWS cannot wrap.
    row_rel   = {1'b0, row_q} - {1'b0, row0_q};
    col_rel   = {1'b0, col_q} - {1'b0, col0_q};
    in_win    = (row_q >= row0_q) && (row_rel < ROW_SPAN) &&
                (col_q >= col0_q) && (col_rel < COL_SPAN);
    wr_en     = beat && in_win;
    last_beat = (row_q == ROW_END) && (col_q == COL_END);
    // Strict compare: ties keep the stored max.
    max_nxt   = (wr_en && (s_axis.tdata > max_q)) ? s_axis.tdata : max_q;
    // Refill the output register whenever it is empty or draining.
    issue     = (state_q == EMIT) && (rd_addr_q != N_A) &&
                (!m_vld_q || m_axis.tready);
    xfer      = m_vld_q && m_axis.tready;

    case (state_q)
      IDLE: begin
        if (ap_start) begin
          row0_d     = (crop_row_start > ROW_LIM) ? ROW_LIM : crop_row_start;
          col0_d     = (crop_col_start > COL_LIM) ? COL_LIM : crop_col_start;
          row_d      = '0;
          col_d      = '0;
          max_d      = '0;
          wr_addr_d  = '0;
          rd_addr_d  = '0;
          sent_d     = '0;
          s_rdy_d    = 1'b1;
          ap_ready_d = 1'b0;
          state_d    = CAPTURE;
        end
      end
      CAPTURE: begin
        if (beat) begin
          if (col_q == COL_END) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (wr_en) wr_addr_d = wr_addr_q + 1'b1;
          max_d = max_nxt;
          if (last_beat) begin
            s_rdy_d    = 1'b0;
            norm_d     = norm_of(max_nxt);
            norm_vld_d = 1'b1;
            state_d    = EMIT;
          end
        end
      end
      EMIT: begin
        if (issue) begin
          m_data_d  = mem[rd_addr_q[IW-1:0]];
          m_vld_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end else if (xfer) begin
          m_vld_d = 1'b0;
        end
        if (xfer) begin
          sent_d = sent_q + 1'b1;
          if (sent_q == LAST_A) begin
            m_vld_d    = 1'b0;
            norm_vld_d = 1'b0;
            norm_d     = '0;
            ap_done_d  = 1'b1;
            ap_ready_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      row0_q     <= '0;
      col0_q     <= '0;
      max_q      <= '0;
      m_data_q   <= '0;
      norm_q     <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      sent_q     <= '0;
      ap_ready_q <= 1'b1;
      ap_done_q  <= 1'b0;
      s_rdy_q    <= 1'b0;
      m_vld_q    <= 1'b0;
      norm_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row0_q     <= row0_d;
      col0_q     <= col0_d;
      max_q      <= max_d;
      m_data_q   <= m_data_d;
      norm_q     <= norm_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      sent_q     <= sent_d;
      ap_ready_q <= ap_ready_d;
      ap_done_q  <= ap_done_d;
      s_rdy_q    <= s_rdy_d;
      m_vld_q    <= m_vld_d;
      norm_vld_q <= norm_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr_q[IW-1:0]] <= s_axis.tdata;
  end

  assign ap_ready                = ap_ready_q;
  assign ap_done                 = ap_done_q;
  assign s_axis.tready           = s_rdy_q;
  assign m_axis.tvalid           = m_vld_q;
  assign m_axis.tdata            = m_data_q;
  assign norm_denominator        = norm_q;
  assign norm_denominator_tvalid = norm_vld_q;

endmodule

// File: tb/tb_crop_max_buffer.sv
// Scoreboard bench for crop_max_buffer on an 8x8 frame with a 4x4 window.
// Stimulus pushes expected crop pixels; a monitor pops on each m_axis beat.
module tb_crop_max_buffer;
  localparam int IR = 8;
  localparam int IC = 8;
  localparam int OR = 4;
  localparam int OC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ap_start = 1'b0;
  logic       ap_ready, ap_done;
  logic [2:0] crs = '0;
  logic [2:0] ccs = '0;
  logic [7:0] norm;
  logic       normv;

  crop_max_buffer_if s_if ();
  crop_max_buffer_if m_if ();

  crop_max_buffer #(
    .IN_ROWS(IR), .IN_COLS(IC), .OUT_ROWS(OR), .OUT_COLS(OC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_done(ap_done),
    .crop_row_start(crs),
    .crop_col_start(ccs),
    .s_axis(s_if),
    .m_axis(m_if),
    .norm_denominator(norm),
    .norm_denominator_tvalid(normv)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_norm = '0;
  bit         stall_mode = 1'b0;
  bit         gap_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [7:0] hold;
    bit held;
    held = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      if (ap_done) done_cnt++;
      if (m_if.tvalid) begin
        if (held) chk("stall_data", 32'(m_if.tdata), 32'(hold));
        if (m_if.tready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
          else chk("beat_data", 32'(m_if.tdata), 32'(exp_q.pop_front()));
          chk("norm_valid", 32'(normv), 32'd1);
          chk("norm_value", 32'(norm), 32'(exp_norm));
          held = 1'b0;
        end else begin
          hold = m_if.tdata;
          held = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_ap_ready"}, 32'(ap_ready), 32'd1);
    chk({tag, "_ap_done"}, 32'(ap_done), 32'd0);
    chk({tag, "_s_tready"}, 32'(s_if.tready), 32'd0);
    chk({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
    chk({tag, "_norm_valid"}, 32'(normv), 32'd0);
  endtask

  task automatic send(input logic [7:0] v);
    int t;
    t = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata = v;
    @(negedge clk);
    while (!s_if.tready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("s_tready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic run_frame(input int r0, input int c0, input bit zero,
                           input int abort_after, input bit poke);
    int rr, cc, mx, d0, t;
    logic [7:0] v;
    rr = (r0 > IR - OR) ? IR - OR : r0;
    cc = (c0 > IC - OC) ? IC - OC : c0;
    mx = 0;
    d0 = done_cnt;
    if (abort_after < 0) begin
      for (int r = rr; r < rr + OR; r++)
        for (int c = cc; c < cc + OC; c++) begin
          v = zero ? 8'd0 : 8'(r * IC + c);
          exp_q.push_back(v);
          if (int'(v) > mx) mx = int'(v);
        end
      exp_norm = 8'(mx);
`ifdef CROP_MAX_ZERO_CLAMP_EN
      if (mx == 0) exp_norm = 8'd1;
`endif
    end
    @(posedge clk);
    #1;
    chk("ap_ready_before_start", 32'(ap_ready), 32'd1);
    crs = 3'(r0);
    ccs = 3'(c0);
    ap_start = 1'b1;
    @(posedge clk);
    #1;
    ap_start = 1'b0;
    for (int i = 0; i < IR * IC; i++) begin
      if (i == abort_after) break;
      if (gap_mode) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send(zero ? 8'd0 : 8'(i));
    end
    if (abort_after >= 0) begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_idle("abort_reset");
      chk("abort_tdata", 32'(m_if.tdata), 32'd0);
      chk("abort_norm", 32'(norm), 32'd0);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      return;
    end
    if (poke) begin
      t = 0;
      while (!m_if.tvalid && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("poke_saw_tvalid", 32'(m_if.tvalid), 32'd1);
      crs = 3'd1;
      ccs = 3'd1;
      ap_start = 1'b1;
      @(posedge clk);
      #1;
      ap_start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_idle("after_done");
    repeat (3) @(posedge clk);
    #1;
    chk("single_done_pulse", 32'(done_cnt), 32'(d0 + 1));
    chk("still_idle", 32'(ap_ready), 32'd1);
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_tdata", 32'(m_if.tdata), 32'd0);
    chk("reset_norm", 32'(norm), 32'd0);
    reset = 1'b0;

    run_frame(2, 3, 1'b0, -1, 1'b0);
    run_frame(6, 6, 1'b0, -1, 1'b0);
    run_frame(0, 0, 1'b1, -1, 1'b0);

    gap_mode = 1'b1;
    stall_mode = 1'b1;
    run_frame(2, 3, 1'b0, -1, 1'b0);
    gap_mode = 1'b0;
    stall_mode = 1'b0;

    run_frame(2, 3, 1'b0, 30, 1'b0);
    run_frame(0, 0, 1'b0, -1, 1'b0);

    run_frame(2, 3, 1'b0, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
